// File: rtl/huffman_pkg.sv
// Shared constants, state encoding and symbol-to-entry mapping for the Huffman packer.
package huffman_pkg;

  localparam int unsigned NUM_SYM = 6;
  localparam int unsigned SYM_W   = 8;
  localparam int unsigned CODE_W  = 8;
  localparam int unsigned BUF_W   = 16;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned SEL_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Symbols 1..5 select entries 0..4; everything else falls back to the last entry.
  function automatic logic [SEL_W-1:0] sym_index(input logic [SYM_W-1:0] sym);
    if (sym >= SYM_W'(1) && sym <= SYM_W'(NUM_SYM - 1)) begin
      return SEL_W'(sym - SYM_W'(1));
    end
    return SEL_W'(NUM_SYM - 1);
  endfunction

endpackage

// File: rtl/huffman_code_len.sv
// Code length of an LSB-aligned contiguous mask, i.e. its popcount.
module huffman_code_len
  import huffman_pkg::*;
#(
  parameter int unsigned MASK_W = CODE_W
) (
  input  logic [MASK_W-1:0] mask,
  output logic [LEN_W-1:0]  len
);

  always_comb begin
    len = '0;
    for (int i = 0; i < int'(MASK_W); i++) begin
      len = len + LEN_W'(mask[i]);
    end
  end

endmodule

// File: rtl/huffman_packer.sv
// Encodes gray symbols with a captured Huffman table and packs the codes MSB-first
// into a valid/ready byte stream; sym_last flushes the trailing partial byte.
module huffman_packer #(
  parameter int unsigned SYM_W  = 8,
  parameter int unsigned CODE_W = 8,
  parameter int unsigned BUF_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] HC1,
  input  logic [CODE_W-1:0] HC2,
  input  logic [CODE_W-1:0] HC3,
  input  logic [CODE_W-1:0] HC4,
  input  logic [CODE_W-1:0] HC5,
  input  logic [CODE_W-1:0] HC6,
  input  logic [CODE_W-1:0] M1,
  input  logic [CODE_W-1:0] M2,
  input  logic [CODE_W-1:0] M3,
  input  logic [CODE_W-1:0] M4,
  input  logic [CODE_W-1:0] M5,
  input  logic [CODE_W-1:0] M6,
  input  logic              sym_valid,
  input  logic [SYM_W-1:0]  sym_data,
  input  logic              sym_last,
  output logic              sym_ready,
  output logic              out_valid,
  output logic [7:0]        out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              table_loaded
);

  import huffman_pkg::*;

  localparam int unsigned CNT_W = $clog2(BUF_W + 1);

  state_t                  state_q;
  logic [BUF_W-1:0]        pack_buf_q;
  logic [CNT_W-1:0]        bit_cnt_q;
  logic [CODE_W-1:0]       code_q [NUM_SYM];
  logic [LEN_W-1:0]        len_q  [NUM_SYM];

  logic [CODE_W-1:0]       hc_in  [NUM_SYM];
  logic [CODE_W-1:0]       m_in   [NUM_SYM];
  logic [LEN_W-1:0]        len_c  [NUM_SYM];

  logic                    pop;
  logic                    push;
  logic [SEL_W-1:0]        sel;
  logic [BUF_W-1:0]        buf_pop;
  logic [CNT_W-1:0]        cnt_pop;
  logic [CNT_W-1:0]        shamt;
  logic [BUF_W-1:0]        buf_next;
  logic [CNT_W-1:0]        cnt_next;

  assign hc_in[0] = HC1;
  assign hc_in[1] = HC2;
  assign hc_in[2] = HC3;
  assign hc_in[3] = HC4;
  assign hc_in[4] = HC5;
  assign hc_in[5] = HC6;
  assign m_in[0]  = M1;
  assign m_in[1]  = M2;
  assign m_in[2]  = M3;
  assign m_in[3]  = M4;
  assign m_in[4]  = M5;
  assign m_in[5]  = M6;

  for (genvar g = 0; g < int'(NUM_SYM); g++) begin : g_len
    huffman_code_len #(
      .MASK_W (CODE_W)
    ) u_code_len (
      .mask (m_in[g]),
      .len  (len_c[g])
    );
  end

  // Stream outputs are decoded from registered state only.
  assign sym_ready = (state_q == RUN) && (bit_cnt_q <= CNT_W'(BYTE_W));
  assign out_valid = ((state_q == RUN) && (bit_cnt_q >= CNT_W'(BYTE_W))) ||
                     ((state_q == FLUSH) && (bit_cnt_q != '0));
  assign out_data  = pack_buf_q[BUF_W-1 -: BYTE_W];
  assign out_last  = (state_q == FLUSH) && (bit_cnt_q != '0) &&
                     (bit_cnt_q <= CNT_W'(BYTE_W));

  // Pop first, then append the selected code just below the remaining valid bits.
  always_comb begin
    pop      = out_valid && out_ready;
    push     = sym_valid && sym_ready;
    sel      = sym_index(sym_data);
    buf_pop  = pack_buf_q;
    cnt_pop  = bit_cnt_q;
    shamt    = '0;
    if (pop) begin
      buf_pop = pack_buf_q << BYTE_W;
      cnt_pop = (bit_cnt_q > CNT_W'(BYTE_W)) ? bit_cnt_q - CNT_W'(BYTE_W) : '0;
    end
    buf_next = buf_pop;
    cnt_next = cnt_pop;
    if (push) begin
      shamt    = CNT_W'(int'(BUF_W) - int'(cnt_pop) - int'(len_q[sel]));
      buf_next = buf_pop | (BUF_W'(code_q[sel]) << shamt);
      cnt_next = cnt_pop + CNT_W'(len_q[sel]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pack_buf_q   <= '0;
      bit_cnt_q    <= '0;
      table_loaded <= 1'b0;
      for (int i = 0; i < int'(NUM_SYM); i++) begin
        code_q[i] <= '0;
        len_q[i]  <= '0;
      end
    end else begin
      pack_buf_q <= buf_next;
      bit_cnt_q  <= cnt_next;
      case (state_q)
        IDLE: begin
          if (code_valid) begin
            for (int i = 0; i < int'(NUM_SYM); i++) begin
              code_q[i] <= hc_in[i] & m_in[i];
              len_q[i]  <= len_c[i];
            end
            table_loaded <= 1'b1;
            state_q      <= RUN;
          end
        end
        RUN: begin
          if (push && sym_last) begin
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          // An empty flush (zero-length packet) returns without emitting a byte.
          if ((bit_cnt_q == '0) || (pop && out_last)) begin
            state_q <= RUN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
